// File: rtl/load_store_unit_pkg.sv
// Shared types for the memory stage: operation/exception encodings, FSM states and decode helpers.
package load_store_unit_pkg;

  // bit 3 = store, bit 2 = unsigned load, bits 1:0 = access size
  typedef enum logic [3:0] {
    MEM_LB  = 4'b0000,
    MEM_LH  = 4'b0001,
    MEM_LW  = 4'b0010,
    MEM_NOP = 4'b0011,
    MEM_LBU = 4'b0100,
    MEM_LHU = 4'b0101,
    MEM_SB  = 4'b1000,
    MEM_SH  = 4'b1001,
    MEM_SW  = 4'b1010
  } mem_oper_t;

  typedef enum logic [4:0] {
    LOAD_ADDR_MISALIGNED      = 5'd4,
    LOAD_ACC_FAULT            = 5'd5,
    STORE_AMO_ADDR_MISALIGNED = 5'd6,
    STORE_AMO_ACC_FAULT       = 5'd7,
    NO_TRAP                   = 5'h1F
  } exc_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } lsu_state_t;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;

  function automatic logic mem_is_store(mem_oper_t op);
    return op[3];
  endfunction

  function automatic logic mem_is_unsigned(mem_oper_t op);
    return op[2];
  endfunction

  function automatic logic [1:0] mem_size(mem_oper_t op);
    return op[1:0];
  endfunction

  function automatic logic mem_misaligned(mem_oper_t op, logic [1:0] off);
    case (mem_size(op))
      SIZE_B:  return 1'b0;
      SIZE_H:  return off[0];
      default: return |off;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane alignment: store data shift and byte enables, load extraction with sign/zero extension.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  mem_oper_t   oper_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ldata_o
);

  logic [4:0]  sh_amt;
  logic [31:0] rshift;
  logic        sext;

  assign sh_amt  = {off_i, 3'b000};
  assign wdata_o = wdata_i << sh_amt;
  assign rshift  = rdata_i >> sh_amt;
  assign sext    = ~mem_is_unsigned(oper_i);

  always_comb begin
    be_o    = 4'b1111;
    ldata_o = rshift;
    case (mem_size(oper_i))
      SIZE_B: begin
        be_o    = 4'b0001 << off_i;
        ldata_o = {{24{rshift[7] & sext}}, rshift[7:0]};
      end
      SIZE_H: begin
        be_o    = 4'b0011 << off_i;
        ldata_o = {{16{rshift[15] & sext}}, rshift[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: single-outstanding data bus access with alignment check, load extension and exception reporting.
// LSU_TIMEOUT_EN adds a bus watchdog that aborts a stuck access as an access fault after TIMEOUT_CYCLES.
module load_store_unit
  import load_store_unit_pkg::*;
`ifdef LSU_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
)
`endif
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  input  mem_oper_t   mem_oper_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        flush_i,
  output logic        ready_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic        dmem_err_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output exc_t        exc_o,
  output logic [31:0] exc_tval_o
);

  lsu_state_t  state_q, state_d;
  mem_oper_t   oper_q, oper_d, oper_sel;
  logic [31:0] addr_q, addr_d;
  logic        flushed_q, flushed_d;
  logic        req_q, req_d, we_q, we_d;
  logic [31:0] baddr_q, baddr_d, bwdata_q, bwdata_d;
  logic [3:0]  be_q, be_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d, tval_q, tval_d;
  exc_t        exc_q, exc_d;
  logic [1:0]  off_sel;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_ldata;
  logic        abort, fault, done;

  // IDLE aligns the incoming store; BUSY extracts the load using the latched operation
  assign oper_sel = (state_q == IDLE) ? mem_oper_i : oper_q;
  assign off_sel  = (state_q == IDLE) ? addr_i[1:0] : addr_q[1:0];

  lsu_align u_align (
    .oper_i  (oper_sel),
    .off_i   (off_sel),
    .wdata_i (wdata_i),
    .rdata_i (dmem_rdata_i),
    .be_o    (al_be),
    .wdata_o (al_wdata),
    .ldata_o (al_ldata)
  );

`ifdef LSU_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  assign cnt_d = (state_q == BUSY) ? cnt_q + 16'd1 : 16'd0;
  assign abort = (state_q == BUSY) && (cnt_q == 16'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  assign abort = 1'b0;
`endif

  assign fault = dmem_err_i | abort;
  assign done  = dmem_ack_i | fault;

  always_comb begin
    state_d     = state_q;
    oper_d      = oper_q;
    addr_d      = addr_q;
    flushed_d   = flushed_q;
    req_d       = req_q;
    we_d        = we_q;
    baddr_d     = baddr_q;
    be_d        = be_q;
    bwdata_d    = bwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    exc_d       = NO_TRAP;
    tval_d      = '0;
    case (state_q)
      IDLE: begin
        if (req_valid_i && mem_oper_i != MEM_NOP && !flush_i) begin
          oper_d    = mem_oper_i;
          addr_d    = addr_i;
          flushed_d = 1'b0;
          if (mem_misaligned(mem_oper_i, addr_i[1:0])) begin
            rsp_valid_d = 1'b1;
            exc_d  = mem_is_store(mem_oper_i) ? STORE_AMO_ADDR_MISALIGNED : LOAD_ADDR_MISALIGNED;
            tval_d = addr_i;
          end else begin
            state_d  = BUSY;
            req_d    = 1'b1;
            we_d     = mem_is_store(mem_oper_i);
            baddr_d  = {addr_i[31:2], 2'b00};
            be_d     = al_be;
            bwdata_d = al_wdata;
          end
        end
      end
      BUSY: begin
        flushed_d = flushed_q | flush_i;
        if (done) begin
          state_d  = IDLE;
          req_d    = 1'b0;
          we_d     = 1'b0;
          baddr_d  = '0;
          be_d     = '0;
          bwdata_d = '0;
          // a flush seen at any point during the access kills its response
          if (!flushed_q && !flush_i) begin
            rsp_valid_d = 1'b1;
            if (fault) begin
              exc_d  = mem_is_store(oper_q) ? STORE_AMO_ACC_FAULT : LOAD_ACC_FAULT;
              tval_d = addr_q;
            end else if (!mem_is_store(oper_q)) begin
              rsp_rdata_d = al_ldata;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      oper_q      <= MEM_NOP;
      addr_q      <= '0;
      flushed_q   <= 1'b0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      baddr_q     <= '0;
      be_q        <= '0;
      bwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      exc_q       <= NO_TRAP;
      tval_q      <= '0;
    end else begin
      state_q     <= state_d;
      oper_q      <= oper_d;
      addr_q      <= addr_d;
      flushed_q   <= flushed_d;
      req_q       <= req_d;
      we_q        <= we_d;
      baddr_q     <= baddr_d;
      be_q        <= be_d;
      bwdata_q    <= bwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      exc_q       <= exc_d;
      tval_q      <= tval_d;
    end
  end

  assign ready_o      = (state_q == IDLE);
  assign dmem_req_o   = req_q;
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = baddr_q;
  assign dmem_be_o    = be_q;
  assign dmem_wdata_o = bwdata_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_rdata_o  = rsp_rdata_q;
  assign exc_o        = exc_q;
  assign exc_tval_o   = tval_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: transaction-level model plus expected-response queue checked every cycle.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  mem_oper_t   mem_oper = MEM_NOP;
  logic [31:0] addr = '0, wdata = '0;
  logic        flush = 1'b0;
  logic        ready, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack = 1'b0, dmem_err = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata, exc_tval;
  exc_t        exc;

  always #5 clk = ~clk;

`ifdef LSU_TIMEOUT_EN
  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
`else
  load_store_unit dut (
`endif
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .mem_oper_i(mem_oper),
    .addr_i(addr), .wdata_i(wdata), .flush_i(flush), .ready_o(ready),
    .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .dmem_addr_o(dmem_addr),
    .dmem_be_o(dmem_be), .dmem_wdata_o(dmem_wdata), .dmem_ack_i(dmem_ack),
    .dmem_err_i(dmem_err), .dmem_rdata_i(dmem_rdata), .rsp_valid_o(rsp_valid),
    .rsp_rdata_o(rsp_rdata), .exc_o(exc), .exc_tval_o(exc_tval)
  );

  typedef struct {
    logic [31:0] rdata;
    exc_t        exc;
    logic [31:0] tval;
  } rsp_t;

  int   n_cmp = 0, n_bad = 0;
  rsp_t exp_q[$];
  logic bus_exp = 1'b0, exp_we = 1'b0;
  logic [31:0] exp_addr = '0, exp_wdata = '0;
  logic [3:0]  exp_be = '0;

  // ---- reference model: byte-level arithmetic from the operation's meaning ----
  function automatic int op_bytes(mem_oper_t op);
    case (op)
      MEM_LB, MEM_LBU, MEM_SB: return 1;
      MEM_LH, MEM_LHU, MEM_SH: return 2;
      default:                 return 4;
    endcase
  endfunction

  function automatic bit op_store(mem_oper_t op);
    return op inside {MEM_SB, MEM_SH, MEM_SW};
  endfunction

  function automatic bit op_signed(mem_oper_t op);
    return op inside {MEM_LB, MEM_LH};
  endfunction

  function automatic logic [31:0] model_load(mem_oper_t op, logic [31:0] a, logic [31:0] rd);
    longint unsigned v;
    int nb = op_bytes(op);
    int off = int'(a[1:0]);
    v = {32'd0, rd} / (64'd1 << (8 * off));
    v = v % (64'd1 << (8 * nb));
    if (op_signed(op) && v >= (64'd1 << (8 * nb - 1)))
      v = v + (64'd1 << 32) - (64'd1 << (8 * nb));
    return v[31:0];
  endfunction

  function automatic logic [3:0] model_be(mem_oper_t op, logic [31:0] a);
    int m;
    m = ((1 << op_bytes(op)) - 1) << int'(a[1:0]);
    return m[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(logic [31:0] a, logic [31:0] wd);
    longint unsigned v;
    v = {32'd0, wd} * (64'd1 << (8 * int'(a[1:0])));
    return v[31:0];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // ---- per-cycle compare against the model ----
  always @(negedge clk) begin
    rsp_t e;
    if (!rst) begin
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rsp_unexpected: got pulse exc=%h rdata=%h, expected none (t=%0t)", exc, rsp_rdata, $time);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_exc", 32'(exc), 32'(e.exc));
          chk("rsp_rdata", rsp_rdata, e.rdata);
          if (e.exc != NO_TRAP) chk("rsp_tval", exc_tval, e.tval);
        end
      end else begin
        chk("exc_idle", 32'(exc), 32'(NO_TRAP));
      end
      if (bus_exp) begin
        chk("bus_req", 32'(dmem_req), 32'd1);
        chk("ready_busy", 32'(ready), 32'd0);
        chk("bus_we", 32'(dmem_we), 32'(exp_we));
        chk("bus_addr", dmem_addr, exp_addr);
        chk("bus_be", 32'(dmem_be), 32'(exp_be));
        if (exp_we) chk("bus_wdata", dmem_wdata, exp_wdata);
      end
    end
  end

  // flush_cyc: -1 none, k<delay flush in k-th wait cycle, k==delay flush together with ack/err
  task automatic do_op(input mem_oper_t op, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rd, input int delay, input bit err, input int flush_cyc);
    rsp_t e;
    bit   mis;
    mis = (int'(a[1:0]) % op_bytes(op)) != 0;
    req_valid = 1'b1; mem_oper = op; addr = a; wdata = wd;
    if (mis) begin
      e.rdata = '0;
      e.exc   = op_store(op) ? STORE_AMO_ADDR_MISALIGNED : LOAD_ADDR_MISALIGNED;
      e.tval  = a;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    req_valid = 1'b0; mem_oper = MEM_NOP;
    if (mis) begin
      chk("mis_noreq", 32'(dmem_req), 32'd0);
      @(posedge clk); #1;
      return;
    end
    exp_we = op_store(op); exp_addr = {a[31:2], 2'b00};
    exp_be = model_be(op, a); exp_wdata = model_wdata(a, wd);
    bus_exp = 1'b1;
    for (int i = 0; i < delay; i++) begin
      flush = (i == flush_cyc);
      @(posedge clk); #1;
      flush = 1'b0;
    end
    flush = (flush_cyc == delay);
    e.rdata = (err || op_store(op)) ? 32'd0 : model_load(op, a, rd);
    e.exc   = !err ? NO_TRAP : (op_store(op) ? STORE_AMO_ACC_FAULT : LOAD_ACC_FAULT);
    e.tval  = a;
    if (flush_cyc < 0) exp_q.push_back(e);
    dmem_ack = !err; dmem_err = err; dmem_rdata = rd;
    @(posedge clk); #1;
    dmem_ack = 1'b0; dmem_err = 1'b0; flush = 1'b0; bus_exp = 1'b0;
    dmem_rdata = $urandom;
    chk("req_drop", 32'(dmem_req), 32'd0);
    chk("ready_back", 32'(ready), 32'd1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_exc", 32'(exc), 32'(NO_TRAP));
    chk("rst_be", 32'(dmem_be), 32'd0);
    rst = 1'b0;

    // hand-computed pins on the model itself
    chk("pin_lb", model_load(MEM_LB, 32'h1003, 32'h80FF_1234), 32'hFFFF_FF80);
    chk("pin_lbu", model_load(MEM_LBU, 32'h1003, 32'h80FF_1234), 32'h0000_0080);
    chk("pin_lh", model_load(MEM_LH, 32'h1002, 32'h80FF_1234), 32'hFFFF_80FF);
    chk("pin_lb_be", 32'(model_be(MEM_LB, 32'h1003)), 32'h8);
    chk("pin_sh_be", 32'(model_be(MEM_SH, 32'h2002)), 32'hC);
    chk("pin_sh_wd", model_wdata(32'h2002, 32'h0000_BEEF), 32'hBEEF_0000);

    @(posedge clk); #1;
    do_op(MEM_LB,  32'h1003, 32'h0, 32'h80FF_1234, 0, 1'b0, -1);
    do_op(MEM_LBU, 32'h1003, 32'h0, 32'h80FF_1234, 2, 1'b0, -1);
    do_op(MEM_SH,  32'h2002, 32'h0000_BEEF, 32'h0, 1, 1'b0, -1);
    do_op(MEM_LW,  32'h3001, 32'h0, 32'h0, 0, 1'b0, -1);
    do_op(MEM_SW,  32'h4000, 32'h1234_5678, 32'h0, 5, 1'b0, -1);
    do_op(MEM_LW,  32'h5000, 32'h0, 32'hDEAD_BEEF, 1, 1'b1, -1);
    do_op(MEM_SB,  32'h5004, 32'h0, 32'h0, 0, 1'b1, -1);
    do_op(MEM_LH,  32'h6002, 32'h0, 32'h7FFF_0000, 0, 1'b0, -1);
    do_op(MEM_LHU, 32'h6002, 32'h0, 32'h8001_0000, 1, 1'b0, -1);
    do_op(MEM_LH,  32'h6000, 32'h0, 32'h0000_8001, 0, 1'b0, -1);
    do_op(MEM_LW,  32'h6004, 32'h0, 32'hCAFE_F00D, 0, 1'b0, -1);
    do_op(MEM_SH,  32'h6001, 32'h0000_1111, 32'h0, 0, 1'b0, -1);
    do_op(MEM_SW,  32'h4002, 32'h0, 32'h0, 0, 1'b0, -1);
    do_op(MEM_SB,  32'h7001, 32'h0000_00AB, 32'h0, 0, 1'b0, -1);
    do_op(MEM_LW,  32'h8000, 32'h0, 32'hDEAD_BEEF, 3, 1'b0, 1);
    do_op(MEM_LW,  32'h8004, 32'h0, 32'h1111_2222, 2, 1'b0, 2);
    do_op(MEM_LBU, 32'h8008, 32'h0, 32'h0000_00FE, 0, 1'b0, -1);

    // flush together with a request: nothing is accepted
    req_valid = 1'b1; mem_oper = MEM_LW; addr = 32'h9000; flush = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; mem_oper = MEM_NOP; flush = 1'b0;
    chk("flush_accept_req", 32'(dmem_req), 32'd0);
    chk("flush_accept_ready", 32'(ready), 32'd1);

    // NOP is never accepted
    req_valid = 1'b1; mem_oper = MEM_NOP; addr = 32'h9000;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("nop_req", 32'(dmem_req), 32'd0);

    // stray ack in IDLE must not produce a response
    dmem_ack = 1'b1; dmem_rdata = 32'h5555_5555;
    repeat (2) @(posedge clk);
    #1;
    dmem_ack = 1'b0;
    chk("stray_ack_req", 32'(dmem_req), 32'd0);

    // asynchronous reset in the middle of a bus access
    req_valid = 1'b1; mem_oper = MEM_LW; addr = 32'hA000;
    @(posedge clk); #1;
    req_valid = 1'b0; mem_oper = MEM_NOP;
    chk("pre_rst_req", 32'(dmem_req), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("midrst_req", 32'(dmem_req), 32'd0);
    chk("midrst_ready", 32'(ready), 32'd1);
    chk("midrst_exc", 32'(exc), 32'(NO_TRAP));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_op(MEM_LH, 32'hA002, 32'h0, 32'h8000_0000, 0, 1'b0, -1);

`ifdef LSU_TIMEOUT_EN
    begin
      rsp_t e;
      e.rdata = '0; e.exc = STORE_AMO_ACC_FAULT; e.tval = 32'hB000;
      exp_q.push_back(e);
      req_valid = 1'b1; mem_oper = MEM_SW; addr = 32'hB000; wdata = 32'h0000_0042;
      @(posedge clk); #1;
      req_valid = 1'b0; mem_oper = MEM_NOP;
      exp_we = 1'b1; exp_addr = 32'hB000; exp_be = 4'hF; exp_wdata = 32'h0000_0042;
      bus_exp = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      @(posedge clk); #1;
      bus_exp = 1'b0;
      chk("timeout_req_drop", 32'(dmem_req), 32'd0);
      @(posedge clk); #1;
      dmem_ack = 1'b1;
      @(posedge clk); #1;
      dmem_ack = 1'b0;
    end
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("leftover_rsp", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory stage of the core: accepts one load/store per request from execute (operation encoded as `mem_oper_t`), checks alignment, drives a single-outstanding data-memory bus transaction, and returns sign/zero-extended load data or an `exc_t` exception to writeback. Sits between the execute stage and the data memory and stalls the pipeline while a transaction is in flight.

## Interface
- `TIMEOUT_CYCLES`, 255: bus watchdog limit, only used with `LSU_TIMEOUT_EN`.
- `clk_i`  in  1  core clock
- `rst_i`  in  1  asynchronous, active-high reset
- `req_valid_i`  in  1  execute presents an operation
- `mem_oper_i`  in  4 (`mem_oper_t`)  operation; `MEM_NOP` is never accepted
- `addr_i`  in  32  byte address
- `wdata_i`  in  32  store data, value in low bits
- `flush_i`  in  1  kill pending/incoming operation
- `ready_o`  out  1  high only in IDLE
- `dmem_req_o`  out  1  bus request, held until ack/err
- `dmem_we_o`  out  1  1 = store
- `dmem_addr_o`  out  32  word address, `{addr[31:2],2'b00}`
- `dmem_be_o`  out  4  byte enables
- `dmem_wdata_o`  out  32  lane-shifted store data
- `dmem_ack_i`  in  1  transaction done
- `dmem_err_i`  in  1  bus error (wins over ack)
- `dmem_rdata_i`  in  32  read word, valid with ack
- `rsp_valid_o`  out  1  one-cycle result pulse
- `rsp_rdata_o`  out  32  extended load data; 0 for stores/exceptions
- `exc_o`  out  5 (`exc_t`)  `NO_TRAP` or exception code
- `exc_tval_o`  out  32  faulting byte address

## Operation
- States: IDLE, BUSY, and (with macro) none extra; response is a registered pulse.
- IDLE: accept when `req_valid_i && mem_oper_i != MEM_NOP && !flush_i`; latch oper, `addr_i[1:0]`, full address.
- Misalignment: LH/LHU/SH with `addr[0]`, LW/SW with `addr[1:0]!=0`. No bus request; next cycle `rsp_valid_o=1`, `exc_o` = `LOAD_ADDR_MISALIGNED` or `STORE_AMO_ADDR_MISALIGNED`, `exc_tval_o=addr`; stay IDLE.
- Aligned: register bus outputs, go BUSY. Byte enables: B → `4'b0001<<a`, H → `4'b0011<<a`, W → `4'b1111`. `dmem_wdata_o = wdata<<(8*a)` (B replicated lanes not required).
- BUSY: hold all `dmem_*` outputs stable. On `dmem_err_i`: `LOAD_ACC_FAULT`/`STORE_AMO_ACC_FAULT`, tval = address. On `dmem_ack_i` only: load data = `dmem_rdata_i>>(8*a)`, LB/LH sign-extend, LBU/LHU zero-extend. Then drop `dmem_req_o`, return IDLE, pulse `rsp_valid_o`.
- `flush_i` in BUSY: transaction completes on the bus (no cancel) but the response is suppressed (`rsp_valid_o` stays 0). Flush with same-cycle accept: flush wins, nothing accepted. Flush in the cycle a response would pulse suppresses it.
- Reset (any state, mid-transaction included): IDLE, `dmem_req_o=0`, all outputs 0, `exc_o=NO_TRAP`, `ready_o=1`. Ack arriving in IDLE is ignored.

## Timing
- Accept at edge N → `dmem_req_o` high from cycle N+1.
- Ack/err sampled at edge M (M ≥ N+1) → `dmem_req_o` low and `rsp_valid_o` high in cycle M+1; next request acceptable at edge M+1 (`ready_o` high in M+1).
- Minimum load/store latency 2 cycles; misaligned response 1 cycle after accept.
- `rsp_*`, `exc_*` registered; valid only while `rsp_valid_o`; otherwise `exc_o=NO_TRAP`.

## Configuration
- `LSU_TIMEOUT_EN` defined: 8-bit-or-wider counter cleared on entering BUSY, increments each BUSY cycle; reaching `TIMEOUT_CYCLES` without ack/err aborts: `dmem_req_o` drops, access-fault response as for `dmem_err_i`. Late ack afterwards ignored.
- Undefined: no counter, BUSY waits indefinitely.

## Structure
- Package additions: `lsu_state_t` (IDLE, BUSY), helper function `mem_is_store(mem_oper_t)` = MSB, `mem_size` = low 2 bits; reuse existing `mem_oper_t`, `exc_t`.
- Sub-module `lsu_align`: combinational load extraction/extension and store lane shift + byte-enable generation.

## Test plan
- LB at 0x1003, rdata 0x80FF_1234 → `rsp_rdata_o`=0xFFFF_FF80; LBU same → 0x0000_0080; `dmem_addr_o`=0x1000, be=0001<<3=1000.
- SH 0x0000_BEEF at 0x2002 → be=1100, wdata=0xBEEF_0000, `dmem_we_o`=1, response rdata 0, `NO_TRAP`.
- LW at 0x3001 → no `dmem_req_o`, next cycle `exc_o=LOAD_ADDR_MISALIGNED`, tval 0x3001.
- SW at 0x4000, ack delayed 5 cycles → req held stable 5+ cycles, `ready_o` low throughout, single `rsp_valid_o` pulse.
- LW with `dmem_err_i` → `LOAD_ACC_FAULT`; flush during BUSY → no response pulse; reset mid-BUSY → req drops immediately.
- With `LSU_TIMEOUT_EN`, TIMEOUT_CYCLES=4, no ack → abort after 4 BUSY cycles, `STORE_AMO_ACC_FAULT` for a store.
